serial_adder_ctrl: RTL and testbench

// Bit-serial N-bit adder built around a single 1-bit full-adder cell.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/full_adder_cell.sv | 16 +
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } sa_state_t;

    localparam int unsigned SA_WIDTH_DEF = 8;

    // Bit-counter width; a 1-bit counter is the floor so tiny widths still elaborate.
    function automatic int unsigned sa_cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned SA_CNT_W = sa_cnt_w(SA_WIDTH_DEF);

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_co
);

    logic w_p;

    assign w_p  = i_a ^ i_b;
    assign o_s  = w_p ^ i_cin;
    assign o_co = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB-first, valid/ready in and out.
// Optional subtract mode via `SERIAL_ADDER_SUB_EN (adds the `sub` input port).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = sa_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [WIDTH-1:0] w_sum_next;

    // Subtract is a + ~b + 1, so only the captured b and initial carry change.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    full_adder_cell u_fa (
        .i_a   (r_a_sr[0]),
        .i_b   (r_b_sr[0]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_co  (w_co)
    );

    assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};

    // Controller FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_sum_sr  <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state  <= S_SHIFT;
                        r_a_sr   <= a;
                        r_b_sr   <= w_b_load;
                        r_carry  <= w_c_load;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_co;
                    if (r_cnt == CNT_LAST) begin
                        r_state   <= S_DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                        sum       <= w_sum_next;
                        cout      <= w_co;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state   <= S_IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed table, corner sequences, random vs model.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        bit         sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer add, or a-b with "no borrow" flag in subtract mode.
    function automatic logic [8:0] ref_model(input logic [7:0] ra, input logic [7:0] rb,
                                             input logic rc, input bit rs);
        if (rs)
            return {(ra >= rb) ? 1'b1 : 1'b0, 8'(ra - rb)};
        return 9'(ra) + 9'(rb) + 9'(rc);
    endfunction

    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                         input bit os, input logic [7:0] es, input logic ec, input int hold);
        int lat;
        logic [7:0] held;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = oa; b = ob; cin = oc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = os;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_shift", 32'(in_ready), 32'd0);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(WIDTH));
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        held = sum;
        // Backpressure: result must hold while new requests are ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_sum_stable", 32'(sum), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        chk("idle_sum_kept", 32'(sum), 32'(es));
        if (hold > 0) begin
            @(posedge clk); #1;
            chk("no_queued_op", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [8:0] r;
        logic [7:0] ra, rb;
        logic rc;
        bit rs;

        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
        vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
`endif
        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                  vecs[i].exp_sum, vecs[i].exp_cout, 0);

        // Held result under 5 cycles of backpressure.
        do_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 5);

        // Async reset three bits into a shift discards the partial add.
        a = 8'hC3; b = 8'h3C; cin = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_result", 32'(res_valid), 32'd0);
        end
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 0);

        for (int n = 0; n < 300; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = ref_model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, r[7:0], r[8], $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
